rv32i_exec_unit: RTL and testbench

- Decode-control plus execute datapath for the RV32I 5-stage pipeline.
- Decodes a 32-bit instruction into control signals and selects ALU operand B (register or immediate).
- Runs the ALU, resolves branch/jump and computes the target.
- Registers all results into a one-cycle output stage, the execute→memory boundary. Sits between the decode register and the memory stage.

---
 rtl/riscv_pkg.sv | 72 +++++++
 rtl/rv32i_exec_unit_if.sv | 50 +++++
 rtl/rv32i_alu.sv | 38 +++
 rtl/rv32i_exec_unit.sv | 174 +++++++++++++++++
 tb/tb_rv32i_exec_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32I execute stage.
//   XLEN            datapath width (only 32 supported)
//   OP_*            supported major opcodes
//   alu_op_e        4-bit ALU operation select
//   RES_* / IMM_*   writeback-select and immediate-format codes
//   ex_mem_t        registered execute->memory payload
//   alu_op_dec      funct3/funct7 -> ALU operation for R-type and I-ALU
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] write_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
  } ex_mem_t;

  // funct7[5] selects SUB only for R-type (ADDI has no SUB form), but
  // selects SRA over SRL for both R-type and I-ALU.
  function automatic alu_op_e alu_op_dec(input logic [2:0] funct3,
                                         input logic       alt,
                                         input logic       is_r);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_exec_unit_if.sv
// rv32i_exec_unit_if: bus between the decode register and the execute stage.
//   Inputs to the stage: en_i, flush_i, instr_i, pc_i, rs1_data_i,
//   rs2_data_i, imm_i.
//   Outputs: imm_src_o (combinational) and the registered execute->memory
//   results. illegal_o exists only when ILLEGAL_INSTR_EN is defined.
//   master: the driving pipeline side; slave: the execute unit.
interface rv32i_exec_unit_if;
  import riscv_pkg::*;

  logic            en_i;
  logic            flush_i;
  logic [XLEN-1:0] instr_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [XLEN-1:0] imm_i;

  logic [1:0]      imm_src_o;
  logic [XLEN-1:0] alu_result_o;
  logic            zero_o;
  logic            pc_src_o;
  logic [XLEN-1:0] pc_target_o;
  logic [XLEN-1:0] write_data_o;
  logic [4:0]      rd_o;
  logic            reg_write_o;
  logic            mem_write_o;
  logic [1:0]      result_src_o;
`ifdef ILLEGAL_INSTR_EN
  logic            illegal_o;
`endif

  modport master (
    output en_i, flush_i, instr_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
    input  imm_src_o, alu_result_o, zero_o, pc_src_o, pc_target_o,
           write_data_o, rd_o, reg_write_o, mem_write_o, result_src_o
`ifdef ILLEGAL_INSTR_EN
    , input illegal_o
`endif
  );

  modport slave (
    input  en_i, flush_i, instr_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
    output imm_src_o, alu_result_o, zero_o, pc_src_o, pc_target_o,
           write_data_o, rd_o, reg_write_o, mem_write_o, result_src_o
`ifdef ILLEGAL_INSTR_EN
    , output illegal_o
`endif
  );

endinterface

// File: rtl/rv32i_alu.sv
// rv32i_alu: combinational RV32I ALU.
//   a_i, b_i   operands
//   op_i       operation select (alu_op_e)
//   result_o   result, wraps modulo 2^32
//   zero_o     result_o == 0
module rv32i_alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_e         op_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/rv32i_exec_unit.sv
// rv32i_exec_unit: RV32I decode control + execute datapath with a
// one-cycle execute->memory output register.
//   clk_i   system clock, rising edge
//   rstn_i  synchronous active-low reset
//   bus     rv32i_exec_unit_if.slave (instruction/operands in, results out)
// Optional: define ILLEGAL_INSTR_EN to add the registered bus.illegal_o flag
// for unsupported opcodes, branch funct3 010/011 and bad R-type funct7.
module rv32i_exec_unit
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rstn_i,
  rv32i_exec_unit_if.slave bus
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;

  assign opcode   = bus.instr_i[6:0];
  assign funct3   = bus.instr_i[14:12];
  assign funct7_5 = bus.instr_i[30];

  logic       reg_write;
  logic       mem_write;
  logic       alu_src;
  logic       branch;
  logic       jump;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  alu_op_e    alu_op;

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    result_src = RES_ALU;
    imm_src    = IMM_I;
    alu_op     = ALU_ADD;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = alu_op_dec(funct3, funct7_5, 1'b1);
      end
      OP_I: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = alu_op_dec(funct3, funct7_5, 1'b0);
      end
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = RES_MEM;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = IMM_S;
      end
      OP_BR: begin
        branch  = 1'b1;
        imm_src = IMM_B;
        case (funct3[2:1])
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: alu_op = ALU_SUB;
        endcase
      end
      OP_JAL: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
        imm_src    = IMM_J;
      end
      default: ;
    endcase
  end

  assign bus.imm_src_o = imm_src;

  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  assign src_b = alu_src ? bus.imm_i : bus.rs2_data_i;

  rv32i_alu u_alu (
    .a_i      (bus.rs1_data_i),
    .b_i      (src_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Less-than branches read the SLT/SLTU result bit; 010/011 never take.
  logic taken;
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = alu_zero;
      3'b001:         taken = !alu_zero;
      3'b100, 3'b110: taken = (alu_result == XLEN'(1));
      3'b101, 3'b111: taken = alu_zero;
      default:        taken = 1'b0;
    endcase
  end

  ex_mem_t ex_d;
  ex_mem_t ex_q;

  always_comb begin
    ex_d            = '0;
    ex_d.alu_result = alu_result;
    ex_d.zero       = alu_zero;
    ex_d.pc_src     = (branch & taken) | jump;
    ex_d.pc_target  = bus.pc_i + bus.imm_i;
    ex_d.write_data = bus.rs2_data_i;
    ex_d.rd         = bus.instr_i[11:7];
    ex_d.reg_write  = reg_write;
    ex_d.mem_write  = mem_write;
    ex_d.result_src = result_src;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ex_q <= '0;
    end else if (bus.flush_i) begin
      ex_q <= '0;
    end else if (bus.en_i) begin
      ex_q <= ex_d;
    end
  end

  assign bus.alu_result_o = ex_q.alu_result;
  assign bus.zero_o       = ex_q.zero;
  assign bus.pc_src_o     = ex_q.pc_src;
  assign bus.pc_target_o  = ex_q.pc_target;
  assign bus.write_data_o = ex_q.write_data;
  assign bus.rd_o         = ex_q.rd;
  assign bus.reg_write_o  = ex_q.reg_write;
  assign bus.mem_write_o  = ex_q.mem_write;
  assign bus.result_src_o = ex_q.result_src;

`ifdef ILLEGAL_INSTR_EN
  logic illegal_d;
  logic illegal_q;

  always_comb begin
    illegal_d = 1'b0;
    case (opcode)
      OP_R:   illegal_d = !((bus.instr_i[31:25] == 7'b0000000) ||
                            (bus.instr_i[31:25] == 7'b0100000));
      OP_BR:  illegal_d = (funct3[2:1] == 2'b01);
      OP_I, OP_LW, OP_SW, OP_JAL: illegal_d = 1'b0;
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      illegal_q <= 1'b0;
    end else if (bus.flush_i) begin
      illegal_q <= 1'b0;
    end else if (bus.en_i) begin
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal_o = illegal_q;
`endif

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// tb_rv32i_exec_unit: directed and randomized checks of rv32i_exec_unit
// against an instruction-level reference model of RV32I semantics.
module tb_rv32i_exec_unit;

  logic clk_i = 1'b0;
  logic rstn_i;

  always #5 clk_i = ~clk_i;

  rv32i_exec_unit_if ifc ();

  rv32i_exec_unit dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (ifc)
  );

  typedef struct packed {
    logic [31:0] alu_result;
    logic        zero;
    logic        pc_src;
    logic [31:0] pc_target;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic        illegal;
  } exp_t;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t expq;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // Architectural result of an OP / OP-IMM instruction.
  function automatic logic [31:0] arith(input logic [2:0] f3, input logic sub_or_sra,
                                        input logic is_r, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0:    r = (is_r && sub_or_sra) ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    r = (a < b) ? 32'd1 : 32'd0;
      3'd4:    r = a ^ b;
      3'd5:    r = sub_or_sra ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] imm_src_ref(input logic [31:0] ins);
    case (ins[6:0])
      7'h23:   return 2'b01;
      7'h63:   return 2'b10;
      7'h6F:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm);
    exp_t        e;
    logic [31:0] res;
    logic [2:0]  f3;
    logic        slt, sltu;
    e            = '0;
    f3           = ins[14:12];
    e.rd         = ins[11:7];
    e.write_data = b;
    e.pc_target  = pc + imm;
    res          = a + b;
    slt          = $signed(a) < $signed(b);
    sltu         = a < b;
    case (ins[6:0])
      7'h33: begin
        e.reg_write = 1'b1;
        res         = arith(f3, ins[30], 1'b1, a, b);
        e.illegal   = !(ins[31:25] == 7'h00 || ins[31:25] == 7'h20);
      end
      7'h13: begin
        e.reg_write = 1'b1;
        res         = arith(f3, ins[30], 1'b0, a, imm);
      end
      7'h03: begin
        e.reg_write  = 1'b1;
        e.result_src = 2'b01;
        res          = a + imm;
      end
      7'h23: begin
        e.mem_write = 1'b1;
        res         = a + imm;
      end
      7'h63: begin
        case (f3)
          3'd0: begin res = a - b;        e.pc_src = (a == b); end
          3'd1: begin res = a - b;        e.pc_src = (a != b); end
          3'd4: begin res = {31'd0, slt};  e.pc_src = slt;     end
          3'd5: begin res = {31'd0, slt};  e.pc_src = !slt;    end
          3'd6: begin res = {31'd0, sltu}; e.pc_src = sltu;    end
          3'd7: begin res = {31'd0, sltu}; e.pc_src = !sltu;   end
          default: begin res = a - b; e.pc_src = 1'b0; e.illegal = 1'b1; end
        endcase
      end
      7'h6F: begin
        e.reg_write  = 1'b1;
        e.result_src = 2'b10;
        e.pc_src     = 1'b1;
      end
      default: e.illegal = 1'b1;
    endcase
    e.alu_result = res;
    e.zero       = (res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic check_outputs();
    chk("alu_result", ifc.alu_result_o, expq.alu_result);
    chk("zero", 32'(ifc.zero_o), 32'(expq.zero));
    chk("pc_src", 32'(ifc.pc_src_o), 32'(expq.pc_src));
    chk("pc_target", ifc.pc_target_o, expq.pc_target);
    chk("write_data", ifc.write_data_o, expq.write_data);
    chk("rd", 32'(ifc.rd_o), 32'(expq.rd));
    chk("reg_write", 32'(ifc.reg_write_o), 32'(expq.reg_write));
    chk("mem_write", 32'(ifc.mem_write_o), 32'(expq.mem_write));
    chk("result_src", 32'(ifc.result_src_o), 32'(expq.result_src));
`ifdef ILLEGAL_INSTR_EN
    chk("illegal", 32'(ifc.illegal_o), 32'(expq.illegal));
`endif
  endtask

  // Inputs are already driven; check the combinational imm_src, clock one
  // edge, advance the expected output register, then check it.
  task automatic step();
    exp_t d;
    #1;
    d = model(ifc.instr_i, ifc.pc_i, ifc.rs1_data_i, ifc.rs2_data_i, ifc.imm_i);
    chk("imm_src", 32'(ifc.imm_src_o), 32'(imm_src_ref(ifc.instr_i)));
    @(posedge clk_i);
    if (!rstn_i)           expq = '0;
    else if (ifc.flush_i)  expq = '0;
    else if (ifc.en_i)     expq = d;
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm);
    ifc.instr_i    = ins;
    ifc.pc_i       = pc;
    ifc.rs1_data_i = a;
    ifc.rs2_data_i = b;
    ifc.imm_i      = imm;
  endtask

  initial begin
    logic [6:0] other_ops [7];
    logic [6:0] op;
    logic [6:0] f7;
    logic [31:0] a, b;
    other_ops = '{7'h7F, 7'h37, 7'h17, 7'h67, 7'h0F, 7'h73, 7'h00};
    expq        = '0;
    rstn_i      = 1'b0;
    ifc.en_i    = 1'b1;
    ifc.flush_i = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd0);

    // reset state
    step();
    step();
    chk("reset_alu", ifc.alu_result_o, 32'd0);
    rstn_i = 1'b1;

    // ADD x3,x1,x2
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd0);
    step();
    chk("add_result", ifc.alu_result_o, 32'd12);
    chk("add_rd", 32'(ifc.rd_o), 32'd3);
    chk("add_regwrite", 32'(ifc.reg_write_o), 32'd1);
    chk("add_ressrc", 32'(ifc.result_src_o), 32'd0);
    chk("add_pcsrc", 32'(ifc.pc_src_o), 32'd0);

    drive(mk(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h0, 32'h80000000, 32'd1, 32'd0);
    step();
    chk("sub_wrap", ifc.alu_result_o, 32'h7FFFFFFF);

    drive(mk(7'h20, 5'd2, 5'd1, 3'd5, 5'd3, 7'h33), 32'h0, 32'h80000000, 32'd4, 32'd0);
    step();
    chk("sra", ifc.alu_result_o, 32'hF8000000);

    drive(mk(7'h00, 5'd2, 5'd1, 3'd3, 5'd3, 7'h33), 32'h0, 32'd1, 32'hFFFFFFFF, 32'd0);
    step();
    chk("sltu", ifc.alu_result_o, 32'd1);

    drive(mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63), 32'h100, 32'd9, 32'd9, 32'h10);
    step();
    chk("beq_pcsrc", 32'(ifc.pc_src_o), 32'd1);
    chk("beq_target", ifc.pc_target_o, 32'h110);
    chk("beq_zero", 32'(ifc.zero_o), 32'd1);

    drive(mk(7'h00, 5'd2, 5'd1, 3'd1, 5'd0, 7'h63), 32'h100, 32'd9, 32'd9, 32'h10);
    step();
    chk("bne_pcsrc", 32'(ifc.pc_src_o), 32'd0);

    drive(mk(7'h00, 5'd2, 5'd1, 3'd2, 5'd4, 7'h23), 32'h0, 32'h200, 32'hDEADBEEF, 32'd4);
    #1;
    chk("sw_immsrc", 32'(ifc.imm_src_o), 32'd1);
    step();
    chk("sw_addr", ifc.alu_result_o, 32'h204);
    chk("sw_data", ifc.write_data_o, 32'hDEADBEEF);
    chk("sw_memwrite", 32'(ifc.mem_write_o), 32'd1);
    chk("sw_regwrite", 32'(ifc.reg_write_o), 32'd0);

    // flush with a valid ADD
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd0);
    ifc.flush_i = 1'b1;
    step();
    chk("flush_alu", ifc.alu_result_o, 32'd0);
    chk("flush_rd", 32'(ifc.rd_o), 32'd0);
    ifc.flush_i = 1'b0;

    // load ADD then hold three cycles while inputs change
    step();
    ifc.en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom);
      step();
      chk("hold_alu", ifc.alu_result_o, 32'd12);
    end
    ifc.en_i = 1'b1;

    // reset mid-stream overrides a valid capture
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd0);
    rstn_i = 1'b0;
    step();
    chk("rst_mid_alu", ifc.alu_result_o, 32'd0);
    chk("rst_mid_rw", 32'(ifc.reg_write_o), 32'd0);
    rstn_i = 1'b1;

    // unknown opcode
    drive(32'h0000007F, 32'h40, 32'd3, 32'd4, 32'd8);
    step();
    chk("nop_regwrite", 32'(ifc.reg_write_o), 32'd0);
    chk("nop_memwrite", 32'(ifc.mem_write_o), 32'd0);
    chk("nop_pcsrc", 32'(ifc.pc_src_o), 32'd0);
`ifdef ILLEGAL_INSTR_EN
    chk("nop_illegal", 32'(ifc.illegal_o), 32'd1);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0: op = 7'h33;
        1: op = 7'h13;
        2: op = 7'h03;
        3: op = 7'h23;
        4: op = 7'h63;
        5: op = 7'h6F;
        default: op = other_ops[$urandom_range(0, 6)];
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3: f7 = 7'h00;
        4, 5, 6, 7: f7 = 7'h20;
        default:    f7 = 7'($urandom);
      endcase
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 40));
        default: b = $urandom;
      endcase
      drive(mk(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op),
            $urandom, a, b, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)));
      ifc.en_i    = ($urandom_range(0, 9) < 8);
      ifc.flush_i = ($urandom_range(0, 9) == 0);
      rstn_i      = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
